// File: rtl/h2c_st_mrkr_sched.sv
// H2C streaming marker sequencer: shares the descriptor-bypass-in ST port between user
// pass-through traffic and one injected marker, then waits for its marker response.
module h2c_st_mrkr_sched #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             h2c_dsc_bypass,
  input  logic             mrkr_cmd_vld,
  output logic             mrkr_cmd_rdy,
  input  logic [10:0]      mrkr_cmd_qid,
  input  logic [7:0]       mrkr_cmd_func,
  input  logic [2:0]       mrkr_cmd_port_id,
  input  logic [15:0]      mrkr_cmd_cidx,
  input  logic [119:0]     up_st_dsc,
  input  logic             up_st_vld,
  output logic             up_st_rdy,
  output logic [119:0]     byp_in_st_dsc,
  output logic             byp_in_st_mrkr_req,
  output logic             byp_in_st_no_dma,
  output logic             byp_in_st_sdi,
  output logic             byp_in_st_vld,
  input  logic             byp_in_st_rdy,
  input  logic             byp_out_vld,
  input  logic             byp_out_mrkr_rsp,
  input  logic             byp_out_st_mm,
  input  logic [10:0]      byp_out_qid,
  output logic             mrkr_busy,
  output logic             mrkr_done,
  output logic             mrkr_timeout,
  output logic [CNT_W-1:0] mrkr_tout_cnt
);

  typedef enum logic [2:0] {IDLE, DRAIN, INJECT, WAIT_RSP, DONE, TOUT} state_t;

  typedef struct packed {
    logic [2:0]  port_id;
    logic [15:0] cidx;
    logic [7:0]  func;
    logic [10:0] qid;
  } mrkr_cmd_t;

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  mrkr_cmd_t        cmd_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] tout_cnt_q;
  logic             cmd_acc;
  logic             rsp_match;

  assign cmd_acc   = (state_q == IDLE) & mrkr_cmd_vld & h2c_dsc_bypass;
  assign rsp_match = byp_out_vld & byp_out_mrkr_rsp & ~byp_out_st_mm & (byp_out_qid == cmd_q.qid);

  always_comb begin
    state_d            = state_q;
    mrkr_cmd_rdy       = 1'b0;
    byp_in_st_vld      = up_st_vld;
    up_st_rdy          = byp_in_st_rdy;
    byp_in_st_dsc      = up_st_dsc;
    byp_in_st_mrkr_req = 1'b0;
    byp_in_st_no_dma   = 1'b0;
    byp_in_st_sdi      = 1'b0;
    case (state_q)
      IDLE: begin
        mrkr_cmd_rdy = h2c_dsc_bypass;
        if (cmd_acc) state_d = DRAIN;
      end
      // Keep passing through until no beat is left hanging mid-handshake.
      DRAIN: if (!up_st_vld || byp_in_st_rdy) state_d = INJECT;
      INJECT: begin
        up_st_rdy          = 1'b0;
        byp_in_st_vld      = 1'b1;
        byp_in_st_dsc      = {cmd_q.port_id, cmd_q.cidx, cmd_q.func, cmd_q.qid,
                              1'b1, 1'b1, 16'd0, 64'd0};
        byp_in_st_mrkr_req = 1'b1;
        byp_in_st_no_dma   = 1'b1;
        if (byp_in_st_rdy) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        up_st_rdy     = 1'b0;
        byp_in_st_vld = 1'b0;
        if (rsp_match)             state_d = DONE;
        else if (tmr_q == TMR_LAST) state_d = TOUT;
      end
      DONE, TOUT: begin
        up_st_rdy     = 1'b0;
        byp_in_st_vld = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tmr_q      <= '0;
      tout_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_acc)
        cmd_q <= '{port_id: mrkr_cmd_port_id, cidx: mrkr_cmd_cidx,
                   func: mrkr_cmd_func, qid: mrkr_cmd_qid};
      tmr_q <= (state_q == WAIT_RSP) ? tmr_q + 1'b1 : '0;
      if (state_q == TOUT && tout_cnt_q != '1)
        tout_cnt_q <= tout_cnt_q + 1'b1;
    end
  end

  assign mrkr_busy     = (state_q != IDLE);
  assign mrkr_done     = (state_q == DONE);
  assign mrkr_timeout  = (state_q == TOUT);
  assign mrkr_tout_cnt = tout_cnt_q;

endmodule

// File: tb/tb_h2c_st_mrkr_sched.sv
// Randomized bench for h2c_st_mrkr_sched; expected outcomes come from when (if ever) a
// matching response is offered relative to the marker handshake.
module tb_h2c_st_mrkr_sched;
  localparam int TOUT  = 16;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             axi_aclk = 1'b0;
  logic             axi_aresetn;
  logic             h2c_dsc_bypass;
  logic             mrkr_cmd_vld, mrkr_cmd_rdy;
  logic [10:0]      mrkr_cmd_qid;
  logic [7:0]       mrkr_cmd_func;
  logic [2:0]       mrkr_cmd_port_id;
  logic [15:0]      mrkr_cmd_cidx;
  logic [119:0]     up_st_dsc, byp_in_st_dsc;
  logic             up_st_vld, up_st_rdy;
  logic             byp_in_st_mrkr_req, byp_in_st_no_dma, byp_in_st_sdi;
  logic             byp_in_st_vld, byp_in_st_rdy;
  logic             byp_out_vld, byp_out_mrkr_rsp, byp_out_st_mm;
  logic [10:0]      byp_out_qid;
  logic             mrkr_busy, mrkr_done, mrkr_timeout;
  logic [CNT_W-1:0] mrkr_tout_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_m  = 0;

  always #5 axi_aclk = ~axi_aclk;

  h2c_st_mrkr_sched #(.TIMEOUT_CYC(TOUT), .CNT_W(CNT_W)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .h2c_dsc_bypass(h2c_dsc_bypass),
    .mrkr_cmd_vld(mrkr_cmd_vld), .mrkr_cmd_rdy(mrkr_cmd_rdy), .mrkr_cmd_qid(mrkr_cmd_qid),
    .mrkr_cmd_func(mrkr_cmd_func), .mrkr_cmd_port_id(mrkr_cmd_port_id),
    .mrkr_cmd_cidx(mrkr_cmd_cidx), .up_st_dsc(up_st_dsc), .up_st_vld(up_st_vld),
    .up_st_rdy(up_st_rdy), .byp_in_st_dsc(byp_in_st_dsc),
    .byp_in_st_mrkr_req(byp_in_st_mrkr_req), .byp_in_st_no_dma(byp_in_st_no_dma),
    .byp_in_st_sdi(byp_in_st_sdi), .byp_in_st_vld(byp_in_st_vld),
    .byp_in_st_rdy(byp_in_st_rdy), .byp_out_vld(byp_out_vld),
    .byp_out_mrkr_rsp(byp_out_mrkr_rsp), .byp_out_st_mm(byp_out_st_mm),
    .byp_out_qid(byp_out_qid), .mrkr_busy(mrkr_busy), .mrkr_done(mrkr_done),
    .mrkr_timeout(mrkr_timeout), .mrkr_tout_cnt(mrkr_tout_cnt)
  );

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic logic [119:0] rnd_dsc();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[119:0];
  endfunction

  task automatic clr_rsp();
    byp_out_vld = 0; byp_out_mrkr_rsp = 0; byp_out_st_mm = 0; byp_out_qid = '0;
  endtask

  // noise: 0 quiet, 1 random non-matching responses, 2 fixed (st_mm=1 same qid; then qid+1 ST)
  task automatic do_marker(input logic [10:0] qid, input bit pend, input int inj_stall,
                           input int rsp_at, input int noise, input int rst_at);
    logic [119:0] beat, mdsc;
    logic [7:0]   fn;
    logic [2:0]   pt;
    logic [15:0]  cx;
    bit           exp_done;
    int           r;
    fn = 8'($urandom); pt = 3'($urandom); cx = 16'($urandom);
    mdsc = {pt, cx, fn, qid, 1'b1, 1'b1, 16'h0, 64'h0};
    h2c_dsc_bypass = 1; mrkr_cmd_vld = 1;
    mrkr_cmd_qid = qid; mrkr_cmd_func = fn; mrkr_cmd_port_id = pt; mrkr_cmd_cidx = cx;
    beat = rnd_dsc();
    up_st_dsc = beat;
    if (pend) begin up_st_vld = 1; byp_in_st_rdy = 0; end
    else begin up_st_vld = 0; byp_in_st_rdy = 1'($urandom); end
    #1 chk("cmd_rdy", mrkr_cmd_rdy, 1);
    step();
    // Scramble command inputs and bypass mode: neither may affect the marker now.
    mrkr_cmd_vld = 0; mrkr_cmd_qid = 11'($urandom); mrkr_cmd_func = 8'($urandom);
    mrkr_cmd_port_id = 3'($urandom); mrkr_cmd_cidx = 16'($urandom);
    h2c_dsc_bypass = 1'($urandom);
    #1 chk("busy_drain", mrkr_busy, 1);
    if (pend) begin
      chk("drain_vld", byp_in_st_vld, 1);
      chk("drain_dsc", byp_in_st_dsc, beat);
      chk("drain_mreq", byp_in_st_mrkr_req, 0);
      step();
      byp_in_st_rdy = 1;
      #1 chk("drain_urdy", up_st_rdy, 1);
      chk("drain_dsc2", byp_in_st_dsc, beat);
      step();
      up_st_dsc = rnd_dsc();
    end else step();
    for (int i = 0; i <= inj_stall; i++) begin
      byp_in_st_rdy = (i == inj_stall);
      #1 chk("inj_vld", byp_in_st_vld, 1);
      chk("inj_dsc", byp_in_st_dsc, mdsc);
      chk("inj_mreq", byp_in_st_mrkr_req, 1);
      chk("inj_nodma", byp_in_st_no_dma, 1);
      chk("inj_sdi", byp_in_st_sdi, 0);
      chk("inj_urdy", up_st_rdy, 0);
      step();
    end
    byp_in_st_rdy = 1'($urandom);
    for (int k = 1; k <= TOUT; k++) begin
      clr_rsp();
      if (k == rsp_at) begin
        byp_out_vld = 1; byp_out_mrkr_rsp = 1; byp_out_st_mm = 0; byp_out_qid = qid;
      end else if (noise == 2) begin
        if (k == 1) begin byp_out_vld = 1; byp_out_mrkr_rsp = 1; byp_out_st_mm = 1; byp_out_qid = qid; end
        if (k == 2) begin byp_out_vld = 1; byp_out_mrkr_rsp = 1; byp_out_st_mm = 0; byp_out_qid = qid + 11'd1; end
      end else if (noise == 1) begin
        r = $urandom_range(0, 3);
        byp_out_vld = (r != 0); byp_out_mrkr_rsp = (r != 3); byp_out_st_mm = (r == 2);
        byp_out_qid = (r == 1) ? (qid ^ 11'($urandom_range(1, 2047))) : qid;
      end
      if (k == rst_at) axi_aresetn = 0;
      #1 chk("wait_vld", byp_in_st_vld, 0);
      chk("wait_urdy", up_st_rdy, 0);
      chk("wait_done", mrkr_done, 0);
      chk("wait_tout", mrkr_timeout, 0);
      step();
      if (k == rst_at) begin
        clr_rsp();
        #1 chk("rst_busy", mrkr_busy, 0);
        chk("rst_done", mrkr_done, 0);
        chk("rst_tout", mrkr_timeout, 0);
        chk("rst_cnt", mrkr_tout_cnt, 0);
        cnt_m = 0;
        axi_aresetn = 1; up_st_vld = 0;
        step();
        chk("rst_post_done", mrkr_done, 0);
        chk("rst_post_tout", mrkr_timeout, 0);
        return;
      end
      if (k == rsp_at) break;
    end
    clr_rsp();
    exp_done = (rsp_at >= 1) && (rsp_at <= TOUT);
    if (!exp_done && cnt_m < CMAX) cnt_m++;
    #1 chk("done", mrkr_done, exp_done);
    chk("tout", mrkr_timeout, !exp_done);
    chk("busy_end", mrkr_busy, 1);
    step();
    up_st_vld = 0;
    #1 chk("done_off", mrkr_done, 0);
    chk("tout_off", mrkr_timeout, 0);
    chk("busy_idle", mrkr_busy, 0);
    chk("tout_cnt", mrkr_tout_cnt, cnt_m);
  endtask

  initial begin
    logic [119:0] b;
    axi_aresetn = 0; h2c_dsc_bypass = 0; mrkr_cmd_vld = 0;
    mrkr_cmd_qid = '0; mrkr_cmd_func = '0; mrkr_cmd_port_id = '0; mrkr_cmd_cidx = '0;
    b = rnd_dsc(); up_st_dsc = b; up_st_vld = 1; byp_in_st_rdy = 1;
    clr_rsp();
    repeat (3) step();
    chk("rst_busy0", mrkr_busy, 0);
    chk("rst_done0", mrkr_done, 0);
    chk("rst_tout0", mrkr_timeout, 0);
    chk("rst_cnt0", mrkr_tout_cnt, 0);
    chk("rst_cmdrdy0", mrkr_cmd_rdy, 0);
    chk("rst_mreq0", byp_in_st_mrkr_req, 0);
    chk("rst_pass_vld", byp_in_st_vld, 1);
    chk("rst_pass_dsc", byp_in_st_dsc, b);
    axi_aresetn = 1; h2c_dsc_bypass = 1;
    step();

    // idle pass-through, same-cycle
    for (int i = 0; i < 8; i++) begin
      b = rnd_dsc(); up_st_dsc = b; up_st_vld = 1; byp_in_st_rdy = 1;
      #1 chk("pt_dsc", byp_in_st_dsc, b);
      chk("pt_vld", byp_in_st_vld, 1);
      chk("pt_urdy", up_st_rdy, 1);
      chk("pt_mreq", byp_in_st_mrkr_req, 0);
      step();
    end
    up_st_vld = 0;

    // commands gated while bypass mode is off
    h2c_dsc_bypass = 0; mrkr_cmd_vld = 1; mrkr_cmd_qid = 11'd5;
    for (int i = 0; i < 3; i++) begin
      #1 chk("gate_cmdrdy", mrkr_cmd_rdy, 0);
      chk("gate_busy", mrkr_busy, 0);
      chk("gate_mreq", byp_in_st_mrkr_req, 0);
      chk("gate_vld", byp_in_st_vld, 0);
      step();
    end

    // stalled pending beat, qid 5, only the third response matches
    do_marker(11'd5, 1'b1, 1, 3, 2, 0);
    // timeout, then a match on the last timer cycle
    do_marker(11'($urandom), 1'b0, 0, 0, 1, 0);
    do_marker(11'($urandom), 1'b0, 0, TOUT, 1, 0);
    // minimum latency case: response on first wait cycle
    do_marker(11'($urandom), 1'b0, 0, 1, 0, 0);

    repeat (24) do_marker(11'($urandom), 1'($urandom), $urandom_range(0, 2),
                          $urandom_range(0, 20), 1, 0);
    // saturate the timeout counter
    repeat (CMAX + 1) do_marker(11'($urandom), 1'b0, 0, 0, 1, 0);
    chk("cnt_sat", mrkr_tout_cnt, CMAX);

    // reset in WAIT_RSP
    do_marker(11'd7, 1'b0, 0, 0, 0, 5);
    do_marker(11'd9, 1'b1, 0, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
